pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage buffer between CPU stages, e.g. MEM->WB and EX->MEM.
- Successor to the fixed-field stage registers, which have only a global go/clear.
- Adds a valid/ready handshake, an optional 2-entry skid for registered backpressure, a synchronous flush, a freeze input, bubble zeroing and a saturating stall counter.
- Payload is an opaque DATA_W bus. Callers concatenate fields such as {syscall, WE, RW, A, w}.

Parameters:
- DATA_W, 70, payload width in bits (1+1+4+32+32 for the MEM/WB bundle).
- SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- ZERO_BUBBLE, 1, 1 = out_data is forced to all-zero whenever out_valid=0; 0 = out_data holds its last value.
- CNT_W, 16, width of the stall counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- flush, input, 1, synchronous clear of all entries (replaces clear).
- hold, input, 1, freezes the stage (inverse of go).
- in_valid, input, 1, upstream beat present.
- in_data, input, DATA_W, upstream payload.
- in_ready, output, 1, stage can accept a beat.
- out_valid, output, 1, downstream beat present.
- out_data, output, DATA_W, downstream payload.
- out_ready, input, 1, downstream accepts.
- occupancy, output, 2, number of held entries (0..2; 0..1 when SKID=0).
- stall_cnt, output, CNT_W, saturating count of backpressure cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): all entries invalid, out_valid=0, out_data=0, occupancy=0, stall_cnt=0. in_ready follows the combinational rules below.
- Transfers:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Both are evaluated at the clock edge.
  - Order is strictly FIFO. No beat is duplicated or lost except by flush.
- Priority: flush > hold > handshake.
- flush=1:
  - At the next edge all entries are invalid, occupancy=0 and out_data=0.
  - A beat accepted in the same cycle is discarded.
  - in_ready keeps its normal value during flush.
  - stall_cnt is not cleared.
- hold=1 (flush=0):
  - in_ready=0 and out_valid=0 combinationally, so no transfers occur.
  - Entries are frozen.
  - stall_cnt does not count.
  - out_data is zero if ZERO_BUBBLE=1, else it holds the main entry.
- SKID=0 (states EMPTY, FULL):
  - in_ready = !full | out_ready (combinational pass-through).
  - EMPTY + accept -> FULL.
  - FULL + emit + accept -> FULL with the new data.
  - FULL + emit, no accept -> EMPTY.
  - Latency is 1 cycle; throughput is 1 beat/cycle.
- SKID=1 (states EMPTY, ONE, TWO):
  - in_ready = !skid_valid, a registered value (no ready path from out_ready to in_ready).
  - EMPTY + accept -> ONE.
  - ONE + accept, no emit -> TWO; the new beat goes to the skid entry.
  - ONE + accept + emit -> ONE with the main entry replaced.
  - ONE + emit, no accept -> EMPTY.
  - TWO + emit -> ONE; the skid entry moves to main. Accept is impossible in TWO.
  - Latency is 1 cycle; full throughput with out_ready held high.
- Outputs:
  - out_valid = main entry valid & !hold.
  - out_data = main payload, or zero per ZERO_BUBBLE.
  - occupancy is the registered entry count.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation: immediate return to reset values regardless of clk. No partial state survives.
- Simultaneous flush + hold: flush wins, and the entries are cleared at that edge.

Test Plan:
- Reset, then in_valid=1 with data 0x1..0x8 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, occupancy=1 steady.
- SKID=1, push 0xA and 0xB with out_ready=0:
  - occupancy=2 and in_ready=0 from the 3rd cycle.
  - stall_cnt counts 1 per cycle.
  - On release, 0xA then 0xB emerge in order and in_ready returns 1 one cycle after the first emit.
- SKID=0, occupancy=1, out_ready=0 -> in_ready=0 combinationally; raising out_ready=1 with in_valid=1 accepts and emits in the same cycle.
- Stage holds 0xA (main) and 0xB (skid), flush=1 for one cycle with in_valid=1 and data 0xC:
  - Next cycle out_valid=0, out_data=0, occupancy=0.
  - 0xC is never emitted.
- hold=1 for 3 cycles with 0x5 held -> out_valid=0, out_data=0 (ZERO_BUBBLE=1), in_ready=0; on release 0x5 is emitted exactly once.
- CNT_W=2, out_ready=0 for 6 cycles with a valid beat -> stall_cnt=3 and stays 3. Assert rst_n=0 mid-clock -> stall_cnt=0 and out_valid=0 without waiting for an edge.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with valid/ready handshake, optional skid entry,
// synchronous flush, freeze (hold), bubble zeroing and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned DATA_W      = 70,
  parameter int unsigned SKID        = 1,
  parameter int unsigned ZERO_BUBBLE = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              main_valid;
  logic              skid_valid;
  logic              hold_eff;
  logic              accept;
  logic              emit;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);
  // flush outranks hold, so a flushing stage keeps its normal handshake outputs
  assign hold_eff   = hold & ~flush;

  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = ~skid_valid & ~hold_eff;
    end else begin
      in_ready = (~main_valid | out_ready) & ~hold_eff;
    end
  end

  assign out_valid = main_valid & ~hold_eff;
  assign out_data  = (ZERO_BUBBLE != 0 && !out_valid) ? '0 : main_data;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      // payload registers are cleared too so a flushed stage shows zero data
      // even when bubbles otherwise keep the last value
      if (flush) begin
        state     <= EMPTY;
        main_data <= '0;
        skid_data <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state     <= ONE;
              main_data <= in_data;
            end
          end
          ONE: begin
            if (accept && emit) begin
              main_data <= in_data;
            end else if (accept) begin
              state     <= TWO;
              skid_data <= in_data;
            end else if (emit) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (emit) begin
              state     <= ONE;
              main_data <= skid_data;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid/zero-bubble stage, single-entry
// hold-last-value stage, and a narrow stall counter stage.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  logic rst_n, rst_n2;

  // DUT0: defaults (SKID=1, ZERO_BUBBLE=1)
  logic        flush0, hold0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [69:0] in_data0, out_data0;
  logic [1:0]  occ0;
  logic [15:0] stall0;
  // DUT1: SKID=0, ZERO_BUBBLE=0
  logic        flush1, hold1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0]  in_data1, out_data1;
  logic [1:0]  occ1;
  logic [15:0] stall1;
  // DUT2: CNT_W=2
  logic        flush2, hold2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  in_data2, out_data2;
  logic [1:0]  occ2;
  logic [1:0]  stall2;

  pipe_stage_buf #(.DATA_W(70), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .hold(hold0),
    .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready0),
    .occupancy(occ0), .stall_cnt(stall0));

  pipe_stage_buf #(.DATA_W(8), .SKID(0), .ZERO_BUBBLE(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .hold(hold1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
    .occupancy(occ1), .stall_cnt(stall1));

  pipe_stage_buf #(.DATA_W(8), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .flush(flush2), .hold(hold2),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
    .occupancy(occ2), .stall_cnt(stall2));

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // scoreboards: expected beats queued on accept, popped on emit
  logic [69:0] q0[$];
  logic [7:0]  q1[$];
  logic [69:0] exp0;
  logic [7:0]  exp1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) begin
          vectors++; errs++;
          $display("FAIL emit0: got unexpected beat 0x%0h, expected none", out_data0);
        end else begin
          exp0 = q0.pop_front();
          chk("emit0", out_data0, exp0);
        end
      end
      if (flush0) q0.delete();
      else if (in_valid0 && in_ready0) q0.push_back(in_data0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          vectors++; errs++;
          $display("FAIL emit1: got unexpected beat 0x%0h, expected none", out_data1);
        end else begin
          exp1 = q1.pop_front();
          chk("emit1", 70'(out_data1), 70'(exp1));
        end
      end
      if (flush1) q1.delete();
      else if (in_valid1 && in_ready1) q1.push_back(in_data1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_n2 = 1'b0;
    {flush0, hold0, in_valid0, out_ready0} = '0; in_data0 = '0;
    {flush1, hold1, in_valid1, out_ready1} = '0; in_data1 = '0;
    {flush2, hold2, in_valid2, out_ready2} = '0; in_data2 = '0;
    cyc(); cyc();
    chk("rst_out_valid", 70'(out_valid0), 70'(0));
    chk("rst_out_data", out_data0, 70'(0));
    chk("rst_occ", 70'(occ0), 70'(0));
    chk("rst_stall", 70'(stall0), 70'(0));
    chk("rst_in_ready", 70'(in_ready0), 70'(1));
    chk("rst_out_data1", 70'(out_data1), 70'(0));
    cyc(); rst_n = 1'b1; rst_n2 = 1'b1;

    // streaming 1..8 with 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      cyc(); in_valid0 = 1'b1; in_data0 = 70'(i); out_ready0 = 1'b1; #1;
      if (i == 1) chk("lat_first", 70'(out_valid0), 70'(0));
      else begin
        chk("stream_data", out_data0, 70'(i - 1));
        chk("stream_occ", 70'(occ0), 70'(1));
      end
    end
    cyc(); in_valid0 = 1'b0; #1; chk("stream_last", out_data0, 70'(8));
    cyc(); #1; chk("stream_drain", 70'(occ0), 70'(0));

    // skid fill under backpressure
    cyc(); in_valid0 = 1'b1; in_data0 = 70'('hA); out_ready0 = 1'b0; #1;
    chk("skid_rdy0", 70'(in_ready0), 70'(1));
    cyc(); in_data0 = 70'('hB); #1;
    chk("skid_occ1", 70'(occ0), 70'(1));
    chk("skid_data1", out_data0, 70'('hA));
    chk("skid_rdy1", 70'(in_ready0), 70'(1));
    cyc(); in_valid0 = 1'b0; #1;
    chk("skid_occ2", 70'(occ0), 70'(2));
    chk("skid_rdy2", 70'(in_ready0), 70'(0));
    chk("stall_1", 70'(stall0), 70'(1));
    cyc(); #1; chk("stall_2", 70'(stall0), 70'(2));
    cyc(); #1; chk("stall_3", 70'(stall0), 70'(3)); out_ready0 = 1'b1;
    cyc(); #1;
    chk("rel_data", out_data0, 70'('hB));
    chk("rel_occ", 70'(occ0), 70'(1));
    chk("rel_rdy", 70'(in_ready0), 70'(1));
    chk("rel_stall", 70'(stall0), 70'(3));
    cyc(); #1; chk("rel_drain", 70'(occ0), 70'(0));

    // flush with both entries held and a beat offered
    cyc(); in_valid0 = 1'b1; in_data0 = 70'('hA); out_ready0 = 1'b0;
    cyc(); in_data0 = 70'('hB); #1; chk("fl_occ1", 70'(occ0), 70'(1));
    cyc(); flush0 = 1'b1; in_data0 = 70'('hC); #1;
    chk("fl_rdy_two", 70'(in_ready0), 70'(0));
    chk("fl_occ2", 70'(occ0), 70'(2));
    cyc(); flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1; #1;
    chk("fl_valid", 70'(out_valid0), 70'(0));
    chk("fl_data", out_data0, 70'(0));
    chk("fl_occ", 70'(occ0), 70'(0));
    chk("fl_stall", 70'(stall0), 70'(4));
    // flush discards a beat accepted in the same cycle
    cyc(); in_valid0 = 1'b1; in_data0 = 70'('h11); out_ready0 = 1'b0;
    cyc(); flush0 = 1'b1; in_data0 = 70'('hC); #1;
    chk("fl_rdy_one", 70'(in_ready0), 70'(1));
    cyc(); flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1; #1;
    chk("fl2_occ", 70'(occ0), 70'(0));
    chk("fl2_valid", 70'(out_valid0), 70'(0));
    chk("fl2_stall", 70'(stall0), 70'(4));
    cyc(); cyc();

    // flush and hold together: flush wins
    cyc(); in_valid0 = 1'b1; in_data0 = 70'('h22); out_ready0 = 1'b0;
    cyc(); in_valid0 = 1'b0; flush0 = 1'b1; hold0 = 1'b1; #1;
    chk("fh_rdy", 70'(in_ready0), 70'(1));
    cyc(); flush0 = 1'b0; hold0 = 1'b0; out_ready0 = 1'b1; #1;
    chk("fh_occ", 70'(occ0), 70'(0));
    chk("fh_valid", 70'(out_valid0), 70'(0));
    chk("fh_stall", 70'(stall0), 70'(4));

    // hold freezes a held beat for three cycles
    cyc(); in_valid0 = 1'b1; in_data0 = 70'('h5); out_ready0 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc(); in_valid0 = 1'b0; hold0 = 1'b1; #1;
      chk("hold_valid", 70'(out_valid0), 70'(0));
      chk("hold_data", out_data0, 70'(0));
      chk("hold_rdy", 70'(in_ready0), 70'(0));
      chk("hold_occ", 70'(occ0), 70'(1));
    end
    cyc(); hold0 = 1'b0; #1;
    chk("unhold_valid", 70'(out_valid0), 70'(1));
    chk("unhold_data", out_data0, 70'('h5));
    cyc(); #1;
    chk("unhold_once", 70'(out_valid0), 70'(0));
    chk("unhold_occ", 70'(occ0), 70'(0));
    cyc(); cyc();

    // single-entry stage: combinational ready pass-through
    cyc(); in_valid1 = 1'b1; in_data1 = 8'h31; out_ready1 = 1'b0; #1;
    chk("s0_rdy_empty", 70'(in_ready1), 70'(1));
    cyc(); in_data1 = 8'h32; #1;
    chk("s0_rdy_full", 70'(in_ready1), 70'(0));
    chk("s0_occ", 70'(occ1), 70'(1));
    out_ready1 = 1'b1; #1;
    chk("s0_rdy_pass", 70'(in_ready1), 70'(1));
    cyc(); in_valid1 = 1'b0; #1;
    chk("s0_replace", 70'(out_data1), 70'('h32));
    chk("s0_occ_rep", 70'(occ1), 70'(1));
    for (int k = 0; k < 4; k++) begin
      cyc(); in_valid1 = 1'b1; in_data1 = 8'(8'h40 + k); #1;
      chk("s0_stream_rdy", 70'(in_ready1), 70'(1));
    end
    cyc(); in_valid1 = 1'b0; #1;
    chk("s0_last", 70'(out_data1), 70'('h43));
    cyc(); #1;
    chk("s0_empty_valid", 70'(out_valid1), 70'(0));
    chk("s0_keep_data", 70'(out_data1), 70'('h43));
    chk("s0_empty_occ", 70'(occ1), 70'(0));

    // narrow stall counter saturation, then asynchronous reset
    cyc(); in_valid2 = 1'b1; in_data2 = 8'h44; out_ready2 = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      cyc(); in_valid2 = 1'b0; #1;
      chk("sat_stall", 70'(stall2), 70'((j - 1) > 3 ? 3 : (j - 1)));
    end
    @(negedge clk); #2; rst_n2 = 1'b0; #1;
    chk("arst_stall", 70'(stall2), 70'(0));
    chk("arst_valid", 70'(out_valid2), 70'(0));
    chk("arst_occ", 70'(occ2), 70'(0));
    cyc(); rst_n2 = 1'b1;

    cyc(); cyc();
    chk("sb0_leftover", 70'(q0.size()), 70'(0));
    chk("sb1_leftover", 70'(q1.size()), 70'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
